// File: rtl/minirv_lsu_pkg.sv
// minirv_lsu_pkg: shared encodings for the MiniRV load/store unit.
//   size_e  : request access size (byte / half / word / illegal)
//   state_e : LSU sequencing states
//   MEM_MASK_W : byte-enable width of the data-memory port (upper half unused)
package minirv_lsu_pkg;

    localparam int MEM_MASK_W = 8;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_X = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

endpackage

// File: rtl/minirv_lsu_if.sv
// minirv_lsu_if: bundle of the LSU request, response and data-memory port.
//   req_*  : core -> LSU request channel (valid/ready)
//   resp_* : LSU -> core response channel (valid/ready)
//   mem_*  : LSU -> RAM word-addressed, byte-masked port; mem_rdata is
//            combinational from mem_addr.
// Modports:
//   slave  : the LSU itself (accepts requests, drives the memory port)
//   master : the environment (core + RAM) that talks to the LSU
interface minirv_lsu_if
    import minirv_lsu_pkg::*;
#(
    parameter int XLEN = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [XLEN-1:0]       req_addr;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [XLEN-1:0]       req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_err;

    logic                  mem_en;
    logic                  mem_we;
    logic [XLEN-1:0]       mem_addr;
    logic [MEM_MASK_W-1:0] mem_mask;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN-1:0]       mem_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  resp_ready, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_en, mem_we, mem_addr, mem_mask, mem_wdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output resp_ready, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_en, mem_we, mem_addr, mem_mask, mem_wdata
    );

endinterface

// File: rtl/minirv_lsu_align.sv
// minirv_lsu_align: purely combinational lane logic for the LSU.
//   size, off, uns : access size, byte offset within the word, zero-extend
//   wdata          : right-aligned store data
//   rdata          : raw memory word
//   mask           : byte enables ([7:4] always 0)
//   wdata_rep      : store data replicated across all lanes
//   rdata_ext      : extracted and sign/zero-extended load data
//   fault          : access must not reach memory
// Build option: MINIRV_LSU_MISALIGN_TRAP_EN makes misaligned half/word
// accesses fault; otherwise the offset is truncated to the access size.
module minirv_lsu_align
    import minirv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  size_e                 size,
    input  logic [1:0]            off,
    input  logic                  uns,
    input  logic [XLEN-1:0]       wdata,
    input  logic [XLEN-1:0]       rdata,
    output logic [MEM_MASK_W-1:0] mask,
    output logic [XLEN-1:0]       wdata_rep,
    output logic [XLEN-1:0]       rdata_ext,
    output logic                  fault
);
    logic [1:0]      eoff;
    logic [XLEN-1:0] sh;

    always_comb begin
        // Drop the low offset bits a wider access cannot use.
        eoff = off;
        case (size)
            SZ_H:    eoff = {off[1], 1'b0};
            SZ_W:    eoff = 2'b00;
            default: eoff = off;
        endcase

        sh        = rdata >> {eoff, 3'b000};
        mask      = '0;
        wdata_rep = '0;
        rdata_ext = '0;
        case (size)
            SZ_B: begin
                mask[3:0] = 4'b0001 << eoff;
                wdata_rep = {(XLEN/8){wdata[7:0]}};
                rdata_ext = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
            end
            SZ_H: begin
                mask[3:0] = 4'b0011 << eoff;
                wdata_rep = {(XLEN/16){wdata[15:0]}};
                rdata_ext = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
            end
            SZ_W: begin
                mask[3:0] = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = sh;
            end
            default: ;
        endcase
    end

`ifdef MINIRV_LSU_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((size == SZ_H) && off[0]) || ((size == SZ_W) && (off != 2'b00));
    assign fault    = (size == SZ_X) || misalign;
`else
    assign fault    = (size == SZ_X);
`endif

endmodule

// File: rtl/minirv_lsu.sv
// minirv_lsu: single-outstanding load/store initiator for the MiniRV core.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : minirv_lsu_if.slave (request, response and memory port)
// Parameters:
//   MEM_LAT : cycles mem_en is held before mem_rdata is sampled (1..15)
//   XLEN    : data/address width
// Build option: MINIRV_LSU_MISALIGN_TRAP_EN (see minirv_lsu_align).
// Flow: IDLE accepts a request; legal ones spend MEM_LAT cycles in ACCESS,
// faulting ones jump straight to RESP; RESP holds until resp_ready.
module minirv_lsu
    import minirv_lsu_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int XLEN    = 32
) (
    input logic         clk,
    input logic         rst_n,
    minirv_lsu_if.slave bus
);
    localparam logic [3:0] LAT_INIT = 4'(MEM_LAT - 1);

    state_e          state_q, state_d;
    logic [3:0]      cnt_q;
    logic            we_q, uns_q, err_q;
    size_e           size_q;
    logic [XLEN-1:0] addr_q, wdata_q, rdata_q;

    // The align block looks at the live request while idle (for the fault
    // decision) and at the registered request otherwise, so the memory port
    // stays stable for the whole access.
    logic                  idle;
    size_e                 a_size;
    logic [1:0]            a_off;
    logic                  a_uns;
    logic [XLEN-1:0]       a_wdata;
    logic [MEM_MASK_W-1:0] a_mask;
    logic [XLEN-1:0]       a_wrep, a_rext;
    logic                  a_fault;

    assign idle    = (state_q == ST_IDLE);
    assign a_size  = idle ? size_e'(bus.req_size) : size_q;
    assign a_off   = idle ? bus.req_addr[1:0]     : addr_q[1:0];
    assign a_uns   = idle ? bus.req_unsigned      : uns_q;
    assign a_wdata = idle ? bus.req_wdata         : wdata_q;

    minirv_lsu_align #(.XLEN(XLEN)) u_align (
        .size      (a_size),
        .off       (a_off),
        .uns       (a_uns),
        .wdata     (a_wdata),
        .rdata     (bus.mem_rdata),
        .mask      (a_mask),
        .wdata_rep (a_wrep),
        .rdata_ext (a_rext),
        .fault     (a_fault)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.req_valid) state_d = a_fault ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (cnt_q == 4'd0) state_d = ST_RESP;
            ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Request registers, latency counter and response data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SZ_B;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.req_valid) begin
                    we_q    <= bus.req_we;
                    uns_q   <= bus.req_unsigned;
                    size_q  <= size_e'(bus.req_size);
                    addr_q  <= bus.req_addr;
                    wdata_q <= bus.req_wdata;
                    err_q   <= a_fault;
                    rdata_q <= '0;
                    cnt_q   <= LAT_INIT;
                end
                ST_ACCESS: begin
                    if (cnt_q != 4'd0) cnt_q   <= cnt_q - 4'd1;
                    else               rdata_q <= we_q ? '0 : a_rext;
                end
                default: ;
            endcase
        end
    end

    // Outputs: decoded from the state register, so an asynchronous reset
    // drops mem_en/mem_we at once.
    always_comb begin
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.mem_en     = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_mask   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            ST_IDLE: bus.req_ready = 1'b1;
            ST_ACCESS: begin
                bus.mem_en    = 1'b1;
                // Counter still at its load value only in the first cycle.
                bus.mem_we    = we_q && (cnt_q == LAT_INIT);
                bus.mem_addr  = {addr_q[XLEN-1:2], 2'b00};
                bus.mem_mask  = a_mask;
                bus.mem_wdata = a_wrep;
            end
            ST_RESP: bus.resp_valid = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_minirv_lsu.sv
`timescale 1ns/1ps
module tb_minirv_lsu;
    import minirv_lsu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus; sel picks which DUT (MEM_LAT 1 or 3) sees handshakes.
    logic        sel, req_valid, req_we, req_uns, resp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;

    minirv_lsu_if if1 ();
    minirv_lsu_if if3 ();

    minirv_lsu #(.MEM_LAT(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    minirv_lsu #(.MEM_LAT(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    logic [31:0] mem [16] = '{default: 32'h0};

    assign if1.req_valid = req_valid & ~sel;   assign if3.req_valid = req_valid & sel;
    assign if1.resp_ready = resp_ready & ~sel; assign if3.resp_ready = resp_ready & sel;
    assign if1.req_we = req_we;             assign if3.req_we = req_we;
    assign if1.req_addr = req_addr;         assign if3.req_addr = req_addr;
    assign if1.req_size = req_size;         assign if3.req_size = req_size;
    assign if1.req_unsigned = req_uns;      assign if3.req_unsigned = req_uns;
    assign if1.req_wdata = req_wdata;       assign if3.req_wdata = req_wdata;
    assign if1.mem_rdata = mem[if1.mem_addr[5:2]];
    assign if3.mem_rdata = mem[if3.mem_addr[5:2]];

    logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_en, o_mem_we;
    logic [31:0] o_resp_rdata, o_mem_addr, o_mem_wdata;
    logic [7:0]  o_mem_mask;
    assign o_req_ready  = sel ? if3.req_ready  : if1.req_ready;
    assign o_resp_valid = sel ? if3.resp_valid : if1.resp_valid;
    assign o_resp_err   = sel ? if3.resp_err   : if1.resp_err;
    assign o_resp_rdata = sel ? if3.resp_rdata : if1.resp_rdata;
    assign o_mem_en     = sel ? if3.mem_en     : if1.mem_en;
    assign o_mem_we     = sel ? if3.mem_we     : if1.mem_we;
    assign o_mem_addr   = sel ? if3.mem_addr   : if1.mem_addr;
    assign o_mem_wdata  = sel ? if3.mem_wdata  : if1.mem_wdata;
    assign o_mem_mask   = sel ? if3.mem_mask   : if1.mem_mask;

    int nvec = 0, nerr = 0;

    task automatic chk1(input string nm, input logic act, input logic exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // One transaction at a time: accepted when idle and req_valid, then
    // m_lat access cycles (none if faulting), then response until resp_ready.
    bit          m_busy = 0, m_fault, m_we;
    int          m_t, m_lat;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [7:0]  m_mask;

    task automatic model_accept();
        logic [1:0]  off, eo;
        logic [31:0] word, sh;
        off   = req_addr[1:0];
        m_fault = (req_size == 2'd3);
`ifdef MINIRV_LSU_MISALIGN_TRAP_EN
        if ((req_size == 2'd1 && off[0]) || (req_size == 2'd2 && off != 2'd0)) m_fault = 1;
`endif
        eo = (req_size == 2'd0) ? off : (req_size == 2'd1) ? {off[1], 1'b0} : 2'd0;
        m_we   = req_we;
        m_lat  = sel ? 3 : 1;
        m_addr = {req_addr[31:2], 2'b00};
        word   = mem[req_addr[5:2]];
        sh     = word >> (8 * eo);
        case (req_size)
            2'd0: begin
                m_mask  = 8'(1 << eo);
                m_wdata = {4{req_wdata[7:0]}};
                m_rdata = req_uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            end
            2'd1: begin
                m_mask  = 8'(3 << eo);
                m_wdata = {2{req_wdata[15:0]}};
                m_rdata = req_uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            end
            default: begin
                m_mask  = 8'h0F;
                m_wdata = req_wdata;
                m_rdata = word;
            end
        endcase
        if (m_fault || m_we) m_rdata = 32'h0;
        m_busy = 1;
        m_t    = 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_busy = 0;
        else if (!m_busy) begin
            if (req_valid) model_accept();
        end else if ((m_fault || m_t > m_lat) && resp_ready) m_busy = 0;
        else m_t = m_t + 1;
    end

    // ---------------- compare + RAM ----------------
    int          pulses;
    logic [31:0] cap_addr, cap_wdata;
    logic [7:0]  cap_mask;

    always @(negedge clk) begin
        if (rst_n) begin
            if (!m_busy) begin
                chk1("idle_req_ready", o_req_ready, 1'b1);
                chk1("idle_mem_en", o_mem_en, 1'b0);
                chk1("idle_resp_valid", o_resp_valid, 1'b0);
            end else if (!m_fault && m_t <= m_lat) begin
                chk1("acc_req_ready", o_req_ready, 1'b0);
                chk1("acc_resp_valid", o_resp_valid, 1'b0);
                chk1("acc_mem_en", o_mem_en, 1'b1);
                chk1("acc_mem_we", o_mem_we, m_we && m_t == 1);
                chk32("acc_mem_addr", o_mem_addr, m_addr);
                chk32("acc_mem_mask", 32'(o_mem_mask), 32'(m_mask));
                chk32("acc_mem_wdata", o_mem_wdata, m_wdata);
                cap_addr  = o_mem_addr;
                cap_mask  = o_mem_mask;
                cap_wdata = o_mem_wdata;
                if (o_mem_we) pulses++;
            end else begin
                chk1("resp_req_ready", o_req_ready, 1'b0);
                chk1("resp_mem_en", o_mem_en, 1'b0);
                chk1("resp_valid", o_resp_valid, 1'b1);
                chk32("resp_rdata", o_resp_rdata, m_rdata);
                chk1("resp_err", o_resp_err, m_fault);
            end
            if (o_mem_en && o_mem_we)
                for (int b = 0; b < 4; b++)
                    if (o_mem_mask[b]) mem[o_mem_addr[5:2]][8*b +: 8] = o_mem_wdata[8*b +: 8];
        end
    end

    // ---------------- driver ----------------
    logic [31:0] last_rdata;
    logic        last_err;
    int          lat, acc;

    task automatic present(input logic we, input logic [31:0] a, input logic [1:0] sz,
                           input logic u, input logic [31:0] wd);
        req_we = we; req_addr = a; req_size = sz; req_uns = u; req_wdata = wd;
        req_valid = 1;
        pulses = 0; cap_addr = 0; cap_mask = 0; cap_wdata = 0;
    endtask

    task automatic wait_accept(output int cyc);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!m_busy && cyc < 20);
        if (!m_busy) begin
            nvec++; nerr++;
            $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
        end
        req_valid = 0;
    endtask

    task automatic finish(input int d, output int l);
        l = 1;
        while (!o_resp_valid && l < 40) begin @(posedge clk); #1; l++; end
        if (!o_resp_valid) begin
            nvec++; nerr++;
            $display("FAIL resp_timeout: got no resp_valid expected resp_valid within 40 cycles");
        end
        repeat (d) begin @(posedge clk); #1; end
        resp_ready = 1;
        last_rdata = o_resp_rdata;
        last_err   = o_resp_err;
        @(posedge clk); #1;
        resp_ready = 0;
    endtask

    task automatic xact(input logic we, input logic [31:0] a, input logic [1:0] sz,
                        input logic u, input logic [31:0] wd, input int d);
        present(we, a, sz, u, wd);
        wait_accept(acc);
        finish(d, lat);
    endtask

    initial begin
        sel = 0; req_valid = 0; req_we = 0; req_addr = 0; req_size = 0;
        req_uns = 0; req_wdata = 0; resp_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk1("rst_req_ready", o_req_ready, 1'b1);
        chk1("rst_resp_valid", o_resp_valid, 1'b0);
        chk1("rst_mem_en", o_mem_en, 1'b0);
        chk1("rst_mem_we", o_mem_we, 1'b0);
        chk32("rst_mem_addr", o_mem_addr, 32'h0);
        chk32("rst_mem_mask", 32'(o_mem_mask), 32'h0);
        chk32("rst_resp_rdata", o_resp_rdata, 32'h0);
        chk1("rst_resp_err", o_resp_err, 1'b0);
        rst_n = 1;
        @(posedge clk); #1;

        // MEM_LAT = 1
        xact(1, 32'h8000_0010, 2'd2, 0, 32'hDEAD_BEEF, 0);
        chk32("sw_pulses", 32'(pulses), 32'd1);
        chk32("sw_mask", 32'(cap_mask), 32'h0F);
        chk32("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk32("sw_lat", 32'(lat), 32'd2);
        chk1("sw_err", last_err, 1'b0);
        xact(0, 32'h8000_0010, 2'd2, 0, 0, 0);
        chk32("lw_rdata", last_rdata, 32'hDEAD_BEEF);

        xact(1, 32'h8000_0010, 2'd2, 0, 32'h80FF_1234, 0);
        xact(0, 32'h8000_0013, 2'd0, 0, 0, 0);
        chk32("lb_mask", 32'(cap_mask), 32'h08);
        chk32("lb_rdata", last_rdata, 32'hFFFF_FF80);
        xact(0, 32'h8000_0013, 2'd0, 1, 0, 0);
        chk32("lbu_rdata", last_rdata, 32'h0000_0080);

        xact(1, 32'h8000_0002, 2'd1, 0, 32'h0000_ABCD, 0);
        chk32("sh_mask", 32'(cap_mask), 32'h0C);
        chk32("sh_wdata", cap_wdata, 32'hABCD_ABCD);
        xact(1, 32'h8000_0000, 2'd2, 0, 32'h7FFE_0000, 0);
        xact(0, 32'h8000_0002, 2'd1, 0, 0, 0);
        chk32("lh_rdata", last_rdata, 32'h0000_7FFE);

        xact(1, 32'h8000_0031, 2'd0, 0, 32'h0000_00A5, 0);
        chk32("sb_mask", 32'(cap_mask), 32'h02);
        chk32("sb_wdata", cap_wdata, 32'hA5A5_A5A5);

        xact(1, 32'h8000_0004, 2'd2, 0, 32'h1357_9BDF, 0);
        xact(0, 32'h8000_0006, 2'd2, 0, 0, 0);
`ifdef MINIRV_LSU_MISALIGN_TRAP_EN
        chk1("lw_mis_err", last_err, 1'b1);
        chk32("lw_mis_rdata", last_rdata, 32'h0);
        chk32("lw_mis_mask", 32'(cap_mask), 32'h0);
`else
        chk1("lw_mis_err", last_err, 1'b0);
        chk32("lw_mis_rdata", last_rdata, 32'h1357_9BDF);
        chk32("lw_mis_addr", cap_addr, 32'h8000_0004);
`endif
        xact(0, 32'h8000_0010, 2'd3, 0, 0, 0);
        chk1("sz3_err", last_err, 1'b1);
        chk32("sz3_rdata", last_rdata, 32'h0);
        chk32("sz3_mask", 32'(cap_mask), 32'h0);

        // MEM_LAT = 3
        sel = 1;
        xact(1, 32'h8000_0020, 2'd2, 0, 32'hCAFE_F00D, 0);
        chk32("lat3_sw_lat", 32'(lat), 32'd4);
        present(0, 32'h8000_0010, 2'd2, 0, 0);
        wait_accept(acc);
        present(0, 32'h8000_0012, 2'd1, 1, 0);   // waits behind the stalled load
        finish(4, lat);
        chk32("lat3_lw_lat", 32'(lat), 32'd4);
        chk32("lat3_lw_rdata", last_rdata, 32'h80FF_1234);
        wait_accept(acc);
        chk32("b2b_accept_cyc", 32'(acc), 32'd1);
        finish(0, lat);
        chk32("lhu_rdata", last_rdata, 32'h0000_80FF);
        xact(0, 32'h8000_0012, 2'd1, 0, 0, 0);
        chk32("lh_neg_rdata", last_rdata, 32'hFFFF_80FF);

        // Reset in the first ACCESS cycle of a store aborts it.
        present(1, 32'h8000_0020, 2'd2, 0, 32'h1111_1111);
        wait_accept(acc);
        chk1("abort_we_pre", o_mem_we, 1'b1);
        rst_n = 0;
        #1;
        chk1("abort_we", o_mem_we, 1'b0);
        chk1("abort_en", o_mem_en, 1'b0);
        @(posedge clk); #2;
        rst_n = 1;
        #1;
        chk1("abort_req_ready", o_req_ready, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        xact(0, 32'h8000_0020, 2'd2, 0, 0, 0);
        chk32("abort_nowrite", last_rdata, 32'hCAFE_F00D);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
